// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel countdown alarm.
package alarm_pkg;

  typedef enum logic [1:0] {CH_IDLE, CH_RUN, CH_PAUSE, CH_ALARM} ch_state_t;

  // Bits needed for an alarm timer that must reach alarm_sec.
  function automatic int timer_width(input int alarm_sec);
    return (alarm_sec < 1) ? 1 : $clog2(alarm_sec + 1);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One countdown channel: run/pause/alarm FSM, seconds counter and alarm timeout.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int CNT_W     = 9,
  parameter int ALARM_SEC = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_rise,
  input  logic             cancel_rise,
  input  logic             sec_tick,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             expired
);

  localparam int             TW          = timer_width(ALARM_SEC);
  localparam logic [TW-1:0]  ALARM_LIMIT = TW'(ALARM_SEC);

  ch_state_t        state, state_next;
  logic [CNT_W-1:0] count_next;
  logic [TW-1:0]    timer, timer_next;

  // NOTE: async reset clears every register, so outputs fall without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CH_IDLE;
      count <= '0;
      timer <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      timer <= timer_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    timer_next = timer;
    if (cancel_rise) begin
      state_next = CH_IDLE;
      count_next = '0;
    end else if (btn_rise) begin
      case (state)
        CH_IDLE:  if (load_value != '0) begin
                    count_next = load_value;
                    state_next = CH_RUN;
                  end
        CH_RUN:   state_next = CH_PAUSE;
        CH_PAUSE: state_next = CH_RUN;
        CH_ALARM: state_next = CH_IDLE;
        default:  state_next = CH_IDLE;
      endcase
    end else if (sec_tick) begin
      if (state == CH_RUN) begin
        if (count == CNT_W'(1)) begin
          count_next = '0;
          state_next = CH_ALARM;
          timer_next = '0;
        end else if (count != '0) begin
          count_next = count - 1'b1;
        end
      end else if (state == CH_ALARM) begin
        timer_next = timer + 1'b1;
        if (timer_next == ALARM_LIMIT) state_next = CH_IDLE;
      end
    end
  end

  assign running = (state == CH_RUN);
  assign expired = (state == CH_ALARM);

endmodule

// File: rtl/multi_countdown_alarm.sv
// N-channel countdown alarm: shared prescaler, button edge detect, channel select and buzzer.
module multi_countdown_alarm
  import alarm_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 9,
  parameter int ALARM_SEC  = 10,
  parameter int BEEP_PULSE = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel,
  input  logic [CNT_W-1:0]                              load_value,
  input  logic                                          btn,
  input  logic                                          cancel,
  output logic [NUM_CH*CNT_W-1:0]                       time_remaining,
  output logic [NUM_CH-1:0]                             running,
  output logic [NUM_CH-1:0]                             expired,
  output logic                                          buzzer
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HALF  = CLK_HZ / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             sec_phase, beep_phase;
  logic             btn_prev, cancel_prev;
  logic             half_tick, sec_tick, btn_rise, cancel_rise;

  assign half_tick   = (div_cnt == DIV_W'(HALF - 1));
  assign sec_tick    = half_tick & sec_phase;
  assign btn_rise    = btn & ~btn_prev;
  assign cancel_rise = cancel & ~cancel_prev;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      sec_phase   <= 1'b0;
      beep_phase  <= 1'b0;
      btn_prev    <= 1'b0;
      cancel_prev <= 1'b0;
    end else begin
      div_cnt     <= half_tick ? '0 : div_cnt + 1'b1;
      sec_phase   <= sec_phase ^ half_tick;
      btn_prev    <= btn;
      cancel_prev <= cancel;
      if (!(|expired))     beep_phase <= 1'b0;
      else if (half_tick)  beep_phase <= ~beep_phase;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             hit;
    logic [CNT_W-1:0] count;

    // Select values with no matching channel address nothing.
    assign hit = (sel == SEL_W'(i));

    alarm_channel #(
      .CNT_W     (CNT_W),
      .ALARM_SEC (ALARM_SEC)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_rise    (btn_rise & hit),
      .cancel_rise (cancel_rise & hit),
      .sec_tick    (sec_tick),
      .load_value  (load_value),
      .count       (count),
      .running     (running[i]),
      .expired     (expired[i])
    );

    assign time_remaining[i*CNT_W +: CNT_W] = count;
  end

  assign buzzer = (|expired) & ((BEEP_PULSE != 0) ? beep_phase : 1'b1);

endmodule

// File: tb/tb_multi_countdown_alarm.sv
// Directed and randomized bench for multi_countdown_alarm against a seconds-level reference model.
module tb_multi_countdown_alarm;

  localparam int CLK_HZ    = 10;
  localparam int HALF      = CLK_HZ / 2;
  localparam int NUM_CH    = 2;
  localparam int CNT_W     = 9;
  localparam int ALARM_SEC = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [0:0]              sel;
  logic [CNT_W-1:0]        load_value;
  logic                    btn, cancel;
  logic [NUM_CH*CNT_W-1:0] time_remaining;
  logic [NUM_CH-1:0]       running, expired;
  logic                    buzzer;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel mode, seconds left, alarm seconds elapsed.
  int m_st  [NUM_CH];
  int m_cnt [NUM_CH];
  int m_tmr [NUM_CH];
  bit m_beep;
  int k;
  bit p_btn, p_cancel;

  multi_countdown_alarm #(
    .CLK_HZ     (CLK_HZ),
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .ALARM_SEC  (ALARM_SEC),
    .BEEP_PULSE (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sel            (sel),
    .load_value     (load_value),
    .btn            (btn),
    .cancel         (cancel),
    .time_remaining (time_remaining),
    .running        (running),
    .expired        (expired),
    .buzzer         (buzzer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit any_alarm();
    for (int i = 0; i < NUM_CH; i++) if (m_st[i] == M_ALARM) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_st[i] = M_IDLE; m_cnt[i] = 0; m_tmr[i] = 0;
    end
    m_beep = 0; k = 0; p_btn = 0; p_cancel = 0;
  endtask

  // Edge k after reset release: half-second events every HALF edges, seconds every CLK_HZ edges.
  task automatic model_edge();
    bit half, sec, br, cr;
    k++;
    half = (k % HALF == 0);
    sec  = (k % CLK_HZ == 0);
    if (!any_alarm()) m_beep = 0;
    else if (half)    m_beep = !m_beep;
    br = btn && !p_btn;
    cr = cancel && !p_cancel;
    p_btn = btn; p_cancel = cancel;
    for (int i = 0; i < NUM_CH; i++) begin
      bit me;
      me = (int'(sel) == i);
      if (cr && me) begin
        m_st[i] = M_IDLE; m_cnt[i] = 0;
      end else if (br && me) begin
        case (m_st[i])
          M_IDLE:  if (load_value != 0) begin m_cnt[i] = int'(load_value); m_st[i] = M_RUN; end
          M_RUN:   m_st[i] = M_PAUSE;
          M_PAUSE: m_st[i] = M_RUN;
          default: m_st[i] = M_IDLE;
        endcase
      end else if (sec) begin
        if (m_st[i] == M_RUN) begin
          if (m_cnt[i] == 1) begin m_cnt[i] = 0; m_st[i] = M_ALARM; m_tmr[i] = 0; end
          else m_cnt[i] = m_cnt[i] - 1;
        end else if (m_st[i] == M_ALARM) begin
          m_tmr[i] = m_tmr[i] + 1;
          if (m_tmr[i] == ALARM_SEC) m_st[i] = M_IDLE;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("time_remaining[%0d]@%0d", i, k), 32'(time_remaining[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
      check($sformatf("running[%0d]@%0d", i, k), 32'(running[i]), 32'(m_st[i] == M_RUN));
      check($sformatf("expired[%0d]@%0d", i, k), 32'(expired[i]), 32'(m_st[i] == M_ALARM));
    end
    check($sformatf("buzzer@%0d", k), 32'(buzzer), 32'(any_alarm() && m_beep));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int ch);
    sel = 1'(ch); btn = 1'b1; step();
    btn = 1'b0; step();
  endtask

  task automatic press_cancel(input int ch);
    sel = 1'(ch); cancel = 1'b1; step();
    cancel = 1'b0; step();
  endtask

  initial begin
    int saved;
    reset = 1'b1; btn = 1'b0; cancel = 1'b0; sel = 1'b0; load_value = '0;
    model_reset();

    // Reset held, then released.
    repeat (3) @(negedge clk);
    check("reset_time_remaining", 32'(time_remaining), 32'd0);
    check("reset_buzzer", 32'(buzzer), 32'd0);
    reset = 1'b0;
    #1;
    check_all();

    // Channel 0 counts 3 s down, alarms, then times out.
    sel = 1'b0; load_value = 9'd3; btn = 1'b1; step();
    check("t2_running", 32'(running[0]), 32'd1);
    check("t2_loaded", 32'(time_remaining[CNT_W-1:0]), 32'd3);
    btn = 1'b0;
    cycles(35);
    check("t2_expired", 32'(expired[0]), 32'd1);
    check("t2_zero", 32'(time_remaining[CNT_W-1:0]), 32'd0);
    cycles(30);
    check("t2_timeout", 32'(expired), 32'd0);

    // Pause holds the count; resume continues.
    load_value = 9'd5;
    press(0);
    press(0);
    saved = m_cnt[0];
    cycles(30);
    check("t3_paused_cnt", 32'(time_remaining[CNT_W-1:0]), 32'(saved));
    check("t3_paused_run", 32'(running[0]), 32'd0);
    press(0);
    cycles(25);
    press_cancel(0);

    // Two channels concurrently; both alarms clear on their own.
    load_value = 9'd4; press(0);
    load_value = 9'd2; press(1);
    cycles(80);
    check("t4_expired", 32'(expired), 32'd0);
    check("t4_buzzer", 32'(buzzer), 32'd0);

    // Cancel beats btn in the same cycle; zero load does not start.
    load_value = 9'd5; press(0);
    cycles(3);
    btn = 1'b1; cancel = 1'b1; step();
    check("t5_cancel_run", 32'(running[0]), 32'd0);
    check("t5_cancel_cnt", 32'(time_remaining[CNT_W-1:0]), 32'd0);
    btn = 1'b0; cancel = 1'b0; step();
    load_value = 9'd0; press(0);
    check("t5_zero_load", 32'(running[0]), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) sel = 1'($urandom_range(0, 1));
      btn        = ($urandom_range(0, 19) == 0);
      cancel     = ($urandom_range(0, 99) == 0);
      load_value = 9'($urandom_range(0, 6));
      step();
    end
    btn = 1'b0; cancel = 1'b0;
    step();

    // Asynchronous reset during an alarm.
    press_cancel(1);
    load_value = 9'd1; press(1);
    cycles(12);
    check("t6_alarming", 32'(expired[1]), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_buzzer", 32'(buzzer), 32'd0);
    check("t6_async_expired", 32'(expired), 32'd0);
    check("t6_async_running", 32'(running), 32'd0);
    check("t6_async_time", 32'(time_remaining), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
